// File: rtl/i2s_codec_bridge.sv
// I2S codec bridge: left-slot ADC deserialiser and two-slot DAC serialiser, all on the system clock.
// Optional build macro I2S_CODEC_LOOPBACK_EN adds a `loopback` port that feeds received samples to the DAC.
module i2s_codec_bridge #(
  parameter int data_width  = 16,
  parameter int slot_width  = 32,
  parameter int sync_stages = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bclk,
  input  logic                  lrclk,
  input  logic                  adc_sdata,
  output logic                  dac_sdata,
  output logic [data_width-1:0] in_sample,
  output logic                  sample_ready,
  input  logic [data_width-1:0] out_sample,
  input  logic                  engine_ready,
`ifdef I2S_CODEC_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic                  overrun,
  output logic                  frame_error
);

  localparam int CW = $clog2(slot_width + 1);
  localparam logic [CW-1:0] DW_C    = CW'(data_width);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] RX_UNLOCKED = 3'd0;
  localparam logic [2:0] RX_DELAY    = 3'd1;
  localparam logic [2:0] RX_SHIFT    = 3'd2;
  localparam logic [2:0] RX_DONE     = 3'd3;
  localparam logic [2:0] RX_WAIT     = 3'd4;

  logic [sync_stages-1:0] bclk_sync_r, lrclk_sync_r, sdata_sync_r;
  logic bclk_prev_r, lrclk_prev_r, eng_prev_r;
  logic bclk_s, lrclk_s, sdata_s;
  logic bclk_rise_s, bclk_fall_s, lr_rise_s, lr_fall_s, lr_edge_s;

  logic [2:0]            rx_state_r, rx_state_lr_s, rx_state_n_s;
  logic [CW-1:0]         rx_cnt_r, rx_cnt_n_s;
  logic [data_width-1:0] rx_shift_r, rx_shift_n_s;
  logic                  rx_emit_s, ferr_set_s;

  logic [data_width-1:0] in_sample_r, out_latched_r, tx_load_s;
  logic                  sample_ready_r, overrun_r, frame_error_r;

  logic [data_width-1:0] tx_shift_r, tx_shift_n_s;
  logic [CW-1:0]         tx_cnt_r, tx_cnt_n_s;
  logic                  dac_r, dac_n_s;

  // Synchronise the codec pins and keep the previous synchronised value for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync_r  <= '0;
      lrclk_sync_r <= '0;
      sdata_sync_r <= '0;
      bclk_prev_r  <= 1'b0;
      lrclk_prev_r <= 1'b0;
    end else begin
      bclk_sync_r[0]  <= bclk;
      lrclk_sync_r[0] <= lrclk;
      sdata_sync_r[0] <= adc_sdata;
      for (int i = 1; i < sync_stages; i++) begin
        bclk_sync_r[i]  <= bclk_sync_r[i-1];
        lrclk_sync_r[i] <= lrclk_sync_r[i-1];
        sdata_sync_r[i] <= sdata_sync_r[i-1];
      end
      bclk_prev_r  <= bclk_sync_r[sync_stages-1];
      lrclk_prev_r <= lrclk_sync_r[sync_stages-1];
    end
  end

  assign bclk_s      = bclk_sync_r[sync_stages-1];
  assign lrclk_s     = lrclk_sync_r[sync_stages-1];
  assign sdata_s     = sdata_sync_r[sync_stages-1];
  assign bclk_rise_s = bclk_s & ~bclk_prev_r;
  assign bclk_fall_s = ~bclk_s & bclk_prev_r;
  assign lr_rise_s   = lrclk_s & ~lrclk_prev_r;
  assign lr_fall_s   = ~lrclk_s & lrclk_prev_r;
  assign lr_edge_s   = lr_rise_s | lr_fall_s;

  // RX next state: the lrclk edge is resolved first, then the bclk edge acts on the resulting state
  always_comb begin
    rx_state_lr_s = rx_state_r;
    rx_state_n_s  = rx_state_r;
    rx_cnt_n_s    = rx_cnt_r;
    rx_shift_n_s  = rx_shift_r;
    rx_emit_s     = 1'b0;
    ferr_set_s    = 1'b0;
    case (rx_state_r)
      RX_UNLOCKED: begin
        if (lr_fall_s) rx_state_lr_s = RX_DELAY;
        else           rx_state_lr_s = RX_UNLOCKED;
      end
      RX_DELAY, RX_SHIFT: begin
        if (lr_fall_s) begin
          rx_state_lr_s = RX_DELAY;
          ferr_set_s    = 1'b1;
        end else if (lr_rise_s) begin
          rx_state_lr_s = RX_WAIT;
          ferr_set_s    = 1'b1;
        end else begin
          rx_state_lr_s = rx_state_r;
        end
      end
      RX_DONE: begin
        rx_emit_s     = 1'b1;
        rx_state_lr_s = lr_fall_s ? RX_DELAY : RX_WAIT;
      end
      RX_WAIT: begin
        if (lr_fall_s) rx_state_lr_s = RX_DELAY;
        else           rx_state_lr_s = RX_WAIT;
      end
      default: rx_state_lr_s = RX_UNLOCKED;
    endcase

    rx_state_n_s = rx_state_lr_s;
    case (rx_state_lr_s)
      RX_DELAY: begin
        if (bclk_rise_s) begin
          rx_state_n_s = RX_SHIFT;
          rx_cnt_n_s   = '0;
        end else begin
          rx_state_n_s = RX_DELAY;
        end
      end
      RX_SHIFT: begin
        if (bclk_rise_s) begin
          rx_shift_n_s = {rx_shift_r[data_width-2:0], sdata_s};
          rx_cnt_n_s   = rx_cnt_r + CNT_ONE;
          if (rx_cnt_n_s == DW_C) rx_state_n_s = RX_DONE;
          else                    rx_state_n_s = RX_SHIFT;
        end else begin
          rx_state_n_s = RX_SHIFT;
        end
      end
      default: rx_state_n_s = rx_state_lr_s;
    endcase
  end

  // RX state, received sample, strobe and sticky status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_r     <= RX_UNLOCKED;
      rx_cnt_r       <= '0;
      rx_shift_r     <= '0;
      in_sample_r    <= '0;
      sample_ready_r <= 1'b0;
      overrun_r      <= 1'b0;
      frame_error_r  <= 1'b0;
    end else begin
      rx_state_r     <= rx_state_n_s;
      rx_cnt_r       <= rx_cnt_n_s;
      rx_shift_r     <= rx_shift_n_s;
      sample_ready_r <= rx_emit_s;
      if (rx_emit_s) in_sample_r <= rx_shift_r;
      frame_error_r  <= frame_error_r | ferr_set_s;
      overrun_r      <= overrun_r | (sample_ready_r & ~engine_ready);
    end
  end

  // Latch the engine result on the rising edge of its ready level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_prev_r    <= 1'b0;
      out_latched_r <= '0;
    end else begin
      eng_prev_r <= engine_ready;
      if (engine_ready && !eng_prev_r) out_latched_r <= out_sample;
    end
  end

`ifdef I2S_CODEC_LOOPBACK_EN
  assign tx_load_s = loopback ? in_sample_r : out_latched_r;
`else
  assign tx_load_s = out_latched_r;
`endif

  // TX next state; the bclk fall that coincides with the lrclk edge is the one-bit delay slot
  always_comb begin
    tx_shift_n_s = tx_shift_r;
    tx_cnt_n_s   = tx_cnt_r;
    dac_n_s      = dac_r;
    if (lr_edge_s) begin
      tx_shift_n_s = tx_load_s;
      tx_cnt_n_s   = '0;
      dac_n_s      = 1'b0;
    end else if (bclk_fall_s) begin
      if (tx_cnt_r < DW_C) begin
        dac_n_s      = tx_shift_r[data_width-1];
        tx_shift_n_s = {tx_shift_r[data_width-2:0], 1'b0};
        tx_cnt_n_s   = tx_cnt_r + CNT_ONE;
      end else begin
        dac_n_s = 1'b0;
      end
    end else begin
      dac_n_s = dac_r;
    end
  end

  // TX shift register, bit counter and registered DAC line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift_r <= '0;
      tx_cnt_r   <= '0;
      dac_r      <= 1'b0;
    end else begin
      tx_shift_r <= tx_shift_n_s;
      tx_cnt_r   <= tx_cnt_n_s;
      dac_r      <= dac_n_s;
    end
  end

  assign dac_sdata    = dac_r;
  assign in_sample    = in_sample_r;
  assign sample_ready = sample_ready_r;
  assign overrun      = overrun_r;
  assign frame_error  = frame_error_r;

endmodule
